// File: rtl/fetch_unit_pkg.sv
// Shared types and widths for the 9-bit CPU fetch stage.
package fetch_unit_pkg;

    localparam int unsigned INSTR_W = 9;
    localparam int unsigned REL_W   = 8;
    localparam int unsigned LUT_W   = 2;

    // Redirect kind resolved by the decoder.
    typedef enum logic [1:0] {
        J_NONE = 2'd0,
        J_REL  = 2'd1,
        J_ABS  = 2'd2,
        J_LUT  = 2'd3
    } jmp_t;

    // Run-control state of the fetch stage.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fsm_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory port plus the decoder-facing signals.
interface fetch_unit_if #(
    parameter int unsigned PC_W = 10
);
    import fetch_unit_pkg::*;

    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic [PC_W-1:0]    pc;
    logic               done;
    jmp_t               jmp_op;
    logic               jmp_take;
    logic [REL_W-1:0]   jmp_rel;
    logic [PC_W-1:0]    jmp_abs;
    logic [LUT_W-1:0]   lut_sel;

    // Fetch unit side.
    modport master (
        output imem_addr, instr, instr_valid, pc,
        input  imem_data, done, jmp_op, jmp_take, jmp_rel, jmp_abs, lut_sel
    );

    // Memory / decoder side.
    modport slave (
        input  imem_addr, instr, instr_valid, pc,
        output imem_data, done, jmp_op, jmp_take, jmp_rel, jmp_abs, lut_sel
    );

endinterface

// File: rtl/fetch_unit_pc_next.sv
// Next-PC selection: stall/halt hold, taken redirects, else sequential.
module fetch_unit_pc_next
    import fetch_unit_pkg::*;
#(
    parameter int unsigned     PC_W = 10,
    parameter logic [PC_W-1:0] LJP0 = '0,
    parameter logic [PC_W-1:0] LJP1 = '0,
    parameter logic [PC_W-1:0] LJP2 = '0,
    parameter logic [PC_W-1:0] LJP3 = '0
) (
    input  logic [PC_W-1:0]  pc,
    input  logic             stall,
    input  logic             done,
    input  jmp_t             jmp_op,
    input  logic             jmp_take,
    input  logic [REL_W-1:0] jmp_rel,
    input  logic [PC_W-1:0]  jmp_abs,
    input  logic [LUT_W-1:0] lut_sel,
    output logic [PC_W-1:0]  next_pc_c
);

    logic [PC_W-1:0] rel_ext;
    logic [PC_W-1:0] lut_tgt;

    // Offset is sign-extended so the add wraps modulo 2^PC_W.
    assign rel_ext = PC_W'($signed(jmp_rel));

    // Long-jump table lookup.
    always_comb begin
        lut_tgt = LJP0;
        case (lut_sel)
            2'd0:    lut_tgt = LJP0;
            2'd1:    lut_tgt = LJP1;
            2'd2:    lut_tgt = LJP2;
            default: lut_tgt = LJP3;
        endcase
    end

    // Priority mux; a held instruction never acts on done or a redirect.
    always_comb begin
        next_pc_c = pc + PC_W'(1);
        if (stall || done) begin
            next_pc_c = pc;
        end else if (jmp_take) begin
            case (jmp_op)
                J_REL:   next_pc_c = pc + rel_ext;
                J_ABS:   next_pc_c = jmp_abs;
                J_LUT:   next_pc_c = lut_tgt;
                default: next_pc_c = pc + PC_W'(1);
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// PC register, run/halt control and cycle counter of the fetch stage.
// imem_addr, instr and instr_valid are combinational by construction: the
// memory is read one cycle ahead so redirects cost no bubble.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned     PC_W       = 10,
    parameter logic [PC_W-1:0] START_ADDR = '0,
    parameter logic [PC_W-1:0] LJP0       = '0,
    parameter logic [PC_W-1:0] LJP1       = '0,
    parameter logic [PC_W-1:0] LJP2       = '0,
    parameter logic [PC_W-1:0] LJP3       = '0,
    parameter int unsigned     CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    output logic             finished,
    output logic [CNT_W-1:0] cycle_cnt,
    fetch_unit_if.master     bus
);

    fsm_t             state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             fin_q, fin_d;
    logic [PC_W-1:0]  imem_addr_c;
    logic             instr_valid_c;
    logic [PC_W-1:0]  next_pc_c;

    fetch_unit_pc_next #(
        .PC_W (PC_W),
        .LJP0 (LJP0),
        .LJP1 (LJP1),
        .LJP2 (LJP2),
        .LJP3 (LJP3)
    ) u_pc_next (
        .pc        (pc_q),
        .stall     (stall),
        .done      (bus.done),
        .jmp_op    (bus.jmp_op),
        .jmp_take  (bus.jmp_take),
        .jmp_rel   (bus.jmp_rel),
        .jmp_abs   (bus.jmp_abs),
        .lut_sel   (bus.lut_sel),
        .next_pc_c (next_pc_c)
    );

    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    // State, PC, counter and finished flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= START_ADDR;
            cnt_q   <= '0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            fin_q   <= fin_d;
        end
    end

    // Next-state and fetch-address logic; start always restarts from START_ADDR.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        cnt_d         = cnt_q;
        fin_d         = fin_q;
        imem_addr_c   = pc_q;
        instr_valid_c = 1'b0;
        case (state_q)
            IDLE: begin
                imem_addr_c = START_ADDR;
                if (start) begin
                    state_d = RUN;
                    pc_d    = START_ADDR;
                    cnt_d   = '0;
                    fin_d   = 1'b0;
                end
            end
            RUN: begin
                if (start) begin
                    // Squash the current instruction and refetch the entry point.
                    imem_addr_c = START_ADDR;
                    pc_d        = START_ADDR;
                    cnt_d       = '0;
                end else begin
                    instr_valid_c = 1'b1;
                    imem_addr_c   = next_pc_c;
                    pc_d          = next_pc_c;
                    cnt_d         = cnt_inc;
                    if (!stall && bus.done) begin
                        state_d = HALT;
                        fin_d   = 1'b1;
                    end
                end
            end
            HALT: begin
                imem_addr_c = pc_q;
                if (start) begin
                    imem_addr_c = START_ADDR;
                    state_d     = RUN;
                    pc_d        = START_ADDR;
                    cnt_d       = '0;
                    fin_d       = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.imem_addr   = imem_addr_c;
    assign bus.instr       = bus.imem_data;
    assign bus.instr_valid = instr_valid_c;
    assign bus.pc          = pc_q;
    assign finished        = fin_q;
    assign cycle_cnt       = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected fetches,
// a negedge monitor pops them whenever instr_valid is high.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int unsigned PC_W = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stall;
    logic        finished, finished4;
    logic [15:0] cycle_cnt;
    logic [3:0]  cycle_cnt4;

    fetch_unit_if #(.PC_W(PC_W)) bus ();
    fetch_unit_if #(.PC_W(PC_W)) bus4 ();

    fetch_unit #(
        .PC_W(PC_W), .START_ADDR(10'd0),
        .LJP0(10'h050), .LJP1(10'h060), .LJP2(10'd300), .LJP3(10'h3ff),
        .CNT_W(16)
    ) u_dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .finished(finished), .cycle_cnt(cycle_cnt), .bus(bus)
    );

    // Narrow-counter copy sharing the same stimulus.
    fetch_unit #(
        .PC_W(PC_W), .START_ADDR(10'd0),
        .LJP0(10'h050), .LJP1(10'h060), .LJP2(10'd300), .LJP3(10'h3ff),
        .CNT_W(4)
    ) u_dut4 (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .finished(finished4), .cycle_cnt(cycle_cnt4), .bus(bus4)
    );

    always #5 clk = ~clk;

    // Instruction ROM: word at address a is a[8:0], one-cycle read latency.
    always @(posedge clk) begin
        bus.imem_data  <= 9'(bus.imem_addr);
        bus4.imem_data <= 9'(bus4.imem_addr);
    end

    assign bus4.done     = bus.done;
    assign bus4.jmp_op   = bus.jmp_op;
    assign bus4.jmp_take = bus.jmp_take;
    assign bus4.jmp_rel  = bus.jmp_rel;
    assign bus4.jmp_abs  = bus.jmp_abs;
    assign bus4.lut_sel  = bus.lut_sel;

    typedef struct {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec   = 0;
    int   n_err   = 0;
    int   exp_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_vec++;
        if (act !== 32'(exp)) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock cycle; queues the expected fetch when a live instruction is due.
    task automatic cyc(input bit v, input int p, input int a);
        if (v) begin
            exp_q.push_back('{pc: PC_W'(p), addr: PC_W'(a)});
            exp_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every live instruction must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (bus.instr_valid === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL stream: unexpected valid instr at pc=%0d", bus.pc);
            end else begin
                e = exp_q.pop_front();
                if (bus.pc !== e.pc || bus.instr !== 9'(e.pc) ||
                    bus.imem_addr !== e.addr || bus4.pc !== e.pc) begin
                    n_err++;
                    $display("FAIL stream: got pc=%0d instr=%0d addr=%0d pc4=%0d, expected pc=%0d instr=%0d addr=%0d",
                             bus.pc, bus.instr, bus.imem_addr, bus4.pc, e.pc, 9'(e.pc), e.addr);
                end
            end
        end
    end

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        stall        = 1'b0;
        bus.done     = 1'b0;
        bus.jmp_op   = J_NONE;
        bus.jmp_take = 1'b0;
        bus.jmp_rel  = '0;
        bus.jmp_abs  = '0;
        bus.lut_sel  = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst_valid", bus.instr_valid, 0);
        chk("rst_finished", finished, 0);
        chk("rst_cnt", cycle_cnt, 0);
        chk("rst_pc", bus.pc, 0);
        chk("rst_addr", bus.imem_addr, 0);

        // Start and sequential fetch.
        start = 1'b1;
        #1;
        chk("idle_start_addr", bus.imem_addr, 0);
        exp_cnt = 0;
        cyc(0, 0, 0);
        start = 1'b0;
        for (int i = 0; i < 10; i++) cyc(1, i, i + 1);

        // Redirects.
        bus.jmp_take = 1'b1; bus.jmp_op = J_REL; bus.jmp_rel = 8'hfc;
        cyc(1, 10, 6);
        bus.jmp_take = 1'b0;
        for (int i = 6; i < 10; i++) cyc(1, i, i + 1);
        cyc(1, 10, 11);
        bus.jmp_take = 1'b1; bus.jmp_op = J_ABS; bus.jmp_abs = 10'h3ff;
        cyc(1, 11, 1023);
        bus.jmp_op = J_REL; bus.jmp_rel = 8'd5;
        cyc(1, 1023, 4);
        bus.jmp_op = J_LUT; bus.lut_sel = 2'd2;
        cyc(1, 4, 300);
        bus.jmp_op = J_ABS; bus.jmp_abs = 10'h155;
        cyc(1, 300, 'h155);
        bus.jmp_op = J_NONE;
        cyc(1, 'h155, 'h156);
        bus.jmp_op = J_REL; bus.jmp_rel = 8'd0;
        cyc(1, 'h156, 'h156);
        bus.jmp_op = J_LUT; bus.lut_sel = 2'd1;
        cyc(1, 'h156, 'h060);
        bus.jmp_op = J_ABS; bus.jmp_abs = 10'd7;
        cyc(1, 'h060, 7);

        // Stall masks done and jumps; releasing it halts with pc held.
        stall = 1'b1; bus.done = 1'b1; bus.jmp_abs = 10'h155;
        for (int k = 0; k < 3; k++) begin
            cyc(1, 7, 7);
            chk("stall_no_halt", finished, 0);
        end
        stall = 1'b0;
        cyc(1, 7, 7);
        bus.done = 1'b0; bus.jmp_take = 1'b0; bus.jmp_op = J_NONE;
        #1;
        chk("halt_valid", bus.instr_valid, 0);
        chk("halt_finished", finished, 1);
        chk("halt_pc", bus.pc, 7);
        chk("halt_addr", bus.imem_addr, 7);
        chk("halt_cnt", cycle_cnt, exp_cnt);
        chk("halt_cnt4", cycle_cnt4, (exp_cnt > 15) ? 15 : exp_cnt);
        repeat (3) cyc(0, 0, 0);
        chk("halt_cnt_frozen", cycle_cnt, exp_cnt);

        // Restart from HALT, run 20 cycles, halt, idle 10.
        start = 1'b1;
        #1;
        chk("halt_start_addr", bus.imem_addr, 0);
        exp_cnt = 0;
        cyc(0, 0, 0);
        start = 1'b0;
        chk("start_clr_fin", finished, 0);
        chk("start_clr_cnt", cycle_cnt, 0);
        for (int i = 0; i < 19; i++) cyc(1, i, i + 1);
        bus.done = 1'b1;
        cyc(1, 19, 19);
        bus.done = 1'b0;
        repeat (10) cyc(0, 0, 0);
        chk("run20_cnt", cycle_cnt, exp_cnt);
        chk("run20_cnt_is_20", cycle_cnt, 20);
        chk("run20_cnt4_sat", cycle_cnt4, 15);
        chk("run20_finished", finished, 1);

        // Start while running squashes one instruction and refetches.
        start = 1'b1;
        exp_cnt = 0;
        cyc(0, 0, 0);
        start = 1'b0;
        cyc(1, 0, 1);
        cyc(1, 1, 2);
        cyc(1, 2, 3);
        start = 1'b1;
        #1;
        chk("rerun_valid", bus.instr_valid, 0);
        chk("rerun_addr", bus.imem_addr, 0);
        exp_cnt = 0;
        cyc(0, 0, 0);
        start = 1'b0;
        chk("rerun_cnt", cycle_cnt, 0);
        cyc(1, 0, 1);
        cyc(1, 1, 2);

        // Reset beats start mid-run.
        reset = 1'b1; start = 1'b1;
        cyc(0, 0, 0);
        reset = 1'b0; start = 1'b0;
        chk("mid_rst_valid", bus.instr_valid, 0);
        chk("mid_rst_finished", finished, 0);
        chk("mid_rst_pc", bus.pc, 0);
        chk("mid_rst_cnt", cycle_cnt, 0);
        chk("mid_rst_addr", bus.imem_addr, 0);
        repeat (2) cyc(0, 0, 0);
        chk("mid_rst_idle", bus.instr_valid, 0);

        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
